// File: rtl/pwm_pkg.sv
// Shared PWM definitions: fade FSM state type, default period and duty width,
// and a counter-width helper used by the PWM timing blocks.
package pwm_pkg;

    localparam int PWM_PERIOD = 100;
    localparam int PWM_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        STEP,
        DONE
    } fade_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period counter: counts 0..PERIOD-1 while enabled, clears on clr.
// Ports: clk, reset_n (async low), clr, en in; wrap out (last count, enabled).
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CW = cnt_width(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty fader for a PWM generator: ramps duty_out toward a target in fixed steps,
// one step every hold_periods PWM periods. In: clk, reset_n, start, abort,
// target_duty, step, hold_periods. Out: duty_out, update, busy, done.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int W      = PWM_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] target_duty,
    input  logic [W-1:0] step,
    input  logic [7:0]   hold_periods,
    output logic [W-1:0] duty_out,
    output logic         update,
    output logic         busy,
    output logic         done
);

    localparam int WP = W + 1;
    localparam logic [W:0] PMAX = WP'(PERIOD);

    fade_state_t state, state_n;

    logic [W-1:0] tgt_q;
    logic [W-1:0] step_q;
    logic [7:0]   hold_q;
    logic [7:0]   hcnt;
    logic         wrap;
    logic         last_hold;
    logic [W:0]   up_sum;
    logic [W:0]   dn_gap;
    logic [W-1:0] nxt_duty;
    logic [W-1:0] tgt_in;

    pwm_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != HOLD),
        .en      (state == HOLD),
        .wrap    (wrap)
    );

    assign tgt_in    = ({1'b0, target_duty} > PMAX) ? PMAX[W-1:0]
                                                    : target_duty;
    assign last_hold = (hcnt == hold_q - 8'd1);

    // Next duty saturates at the target in either direction; the extra
    // bit keeps the sum and the gap from wrapping.
    always_comb begin
        up_sum   = {1'b0, duty_out} + {1'b0, step_q};
        dn_gap   = {1'b0, duty_out} - {1'b0, tgt_q};
        nxt_duty = tgt_q;
        if (tgt_q > duty_out) begin
            if (up_sum < {1'b0, tgt_q}) begin
                nxt_duty = up_sum[W-1:0];
            end
        end else if (dn_gap > {1'b0, step_q}) begin
            nxt_duty = duty_out - step_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = HOLD;
            end
            HOLD: begin
                if (abort || (tgt_q == duty_out)) begin
                    state_n = DONE;
                end else if (wrap && last_hold) begin
                    state_n = STEP;
                end
            end
            STEP: begin
                if (abort || (nxt_duty == tgt_q)) begin
                    state_n = DONE;
                end else begin
                    state_n = HOLD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q    <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            hcnt     <= '0;
            duty_out <= '0;
            update   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            update <= 1'b0;
            done   <= (state == DONE);
            busy   <= (state_n != IDLE);

            if ((state == IDLE) && start) begin
                tgt_q  <= tgt_in;
                step_q <= (step == '0) ? W'(1) : step;
                hold_q <= (hold_periods == 8'd0) ? 8'd1 : hold_periods;
            end

            if ((state == STEP) && !abort) begin
                duty_out <= nxt_duty;
                update   <= (nxt_duty != duty_out);
            end

            if (state != HOLD) begin
                hcnt <= '0;
            end else if (wrap) begin
                hcnt <= last_hold ? 8'd0 : hcnt + 8'd1;
            end
        end
    end

endmodule
